ram_memory_responder: RTL and testbench

- Memory-side slave that answers the RAM master port driven by the snoopy bus of the MOESIF cache system. It services read and write requests, including line fills and write-backs.
- Models main memory with a word-addressed backing array and configurable read/write latencies, and completes each access with a four-phase request/functionComplete handshake.
- Optionally clears the array after reset. Flags illegal simultaneous read+write requests.

---
 rtl/ram_memory_responder_pkg.sv | 29 ++
 rtl/ram_memory_responder_ram_array.sv | 30 +++
 rtl/ram_memory_responder.sv | 150 +++++++++++++++
 tb/tb_ram_memory_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_memory_responder_pkg.sv
// RamResponderTypes
// Shared types and helpers for the RAM memory responder.
//   ResponderState : controller states (INIT clears the array, IDLE accepts
//                    requests, WAIT counts down latency, DONE holds the
//                    handshake until the master releases it)
//   ResponderOp    : operation latched from the request
//   latency_width  : width of a down-counter able to hold either latency
package RamResponderTypes;

   typedef enum logic [1:0] {
      INIT,
      IDLE,
      WAIT,
      DONE
   } ResponderState;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } ResponderOp;

   // One spare bit beyond clog2 keeps the width valid when a latency is 1.
   function automatic int latency_width(input int read_latency, input int write_latency);
      int largest;
      largest = (read_latency > write_latency) ? read_latency : write_latency;
      return $clog2(largest) + 1;
   endfunction

endpackage

// File: rtl/ram_memory_responder_ram_array.sv
// ram_array
// Single-port word array with a synchronous write and a combinational read.
// Ports:
//   clock        : write clock
//   write_enable : store write_data at index on the rising edge
//   index        : word index shared by the read and write paths
//   write_data   : word to store
//   read_data    : current contents at index (combinational)
module ram_array #(
   parameter int DATA_WIDTH         = 16,
   parameter int MEMORY_INDEX_WIDTH = 10
) (
   input  logic                          clock,
   input  logic                          write_enable,
   input  logic [MEMORY_INDEX_WIDTH-1:0] index,
   input  logic [DATA_WIDTH-1:0]         write_data,
   output logic [DATA_WIDTH-1:0]         read_data
);

   logic [DATA_WIDTH-1:0] memory [0:(2**MEMORY_INDEX_WIDTH)-1];

   always_ff @(posedge clock) begin
      if (write_enable) begin
         memory[index] <= write_data;
      end
   end

   assign read_data = memory[index];

endmodule

// File: rtl/ram_memory_responder.sv
// ram_memory_responder
// Main-memory slave for the snoopy bus RAM master port. Each read or write
// completes with a four-phase request/functionComplete handshake after a
// configurable latency. The array can optionally be zeroed after reset.
// Ports:
//   clock            : rising-edge clock
//   reset            : synchronous, active-low reset
//   address          : word address, only the low MEMORY_INDEX_WIDTH bits used
//   writeData        : write data, captured together with the request
//   readEnabled      : read request, held until functionComplete
//   writeEnabled     : write request, held until functionComplete
//   readData         : last read result, valid while functionComplete=1
//   functionComplete : access finished, held until both enables drop
//   ready            : array initialised, requests are accepted
//   protocolError    : sticky, both enables seen high in IDLE
module ram_memory_responder
   import RamResponderTypes::*;
#(
   parameter int ADDRESS_WIDTH      = 16,
   parameter int DATA_WIDTH         = 16,
   parameter int MEMORY_INDEX_WIDTH = 10,
   parameter int READ_LATENCY       = 4,
   parameter int WRITE_LATENCY      = 4,
   parameter bit INIT_ON_RESET      = 1'b1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0]    writeData,
   input  logic                     readEnabled,
   input  logic                     writeEnabled,
   output logic [DATA_WIDTH-1:0]    readData,
   output logic                     functionComplete,
   output logic                     ready,
   output logic                     protocolError
);

   localparam int LATENCY_WIDTH = latency_width(READ_LATENCY, WRITE_LATENCY);
   localparam logic [LATENCY_WIDTH-1:0] READ_COUNT  = LATENCY_WIDTH'(READ_LATENCY - 1);
   localparam logic [LATENCY_WIDTH-1:0] WRITE_COUNT = LATENCY_WIDTH'(WRITE_LATENCY - 1);

   ResponderState                 state;
   ResponderOp                    latched_op;
   logic [MEMORY_INDEX_WIDTH-1:0] latched_index;
   logic [DATA_WIDTH-1:0]         latched_data;
   logic [LATENCY_WIDTH-1:0]      counter;
   logic [MEMORY_INDEX_WIDTH-1:0] init_index;

   logic                          array_write_enable;
   logic [MEMORY_INDEX_WIDTH-1:0] array_index;
   logic [DATA_WIDTH-1:0]         array_write_data;
   logic [DATA_WIDTH-1:0]         array_read_data;
   logic                          access_due;

   // Upper address bits alias onto the implemented words.
   generate
      if (ADDRESS_WIDTH > MEMORY_INDEX_WIDTH) begin : g_alias
         logic unused_address_bits;
         assign unused_address_bits = ^address[ADDRESS_WIDTH-1:MEMORY_INDEX_WIDTH];
      end
   endgenerate

   assign access_due = (state == WAIT) && (counter == '0);

   // The array has one port: the INIT sweep owns it while clearing, the
   // latched access owns it otherwise. Writes are gated by reset so an access
   // interrupted by reset is never committed.
   always_comb begin
      array_write_enable = 1'b0;
      array_index        = latched_index;
      array_write_data   = latched_data;
      if (state == INIT) begin
         array_write_enable = reset;
         array_index        = init_index;
         array_write_data   = '0;
      end else if (access_due && (latched_op == OP_WRITE)) begin
         array_write_enable = reset;
      end
   end

   ram_array #(
      .DATA_WIDTH        (DATA_WIDTH),
      .MEMORY_INDEX_WIDTH(MEMORY_INDEX_WIDTH)
   ) u_ram_array (
      .clock       (clock),
      .write_enable(array_write_enable),
      .index       (array_index),
      .write_data  (array_write_data),
      .read_data   (array_read_data)
   );

   // Controller: clears the array, latches a single request, counts its
   // latency and then holds functionComplete until the master releases.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (INIT_ON_RESET) begin
            state <= INIT;
            ready <= 1'b0;
         end else begin
            state <= IDLE;
            ready <= 1'b1;
         end
         functionComplete <= 1'b0;
         readData         <= '0;
         protocolError    <= 1'b0;
         counter          <= '0;
         init_index       <= '0;
      end else begin
         case (state)
            INIT: begin
               init_index <= init_index + 1'b1;
               if (init_index == '1) begin
                  ready <= 1'b1;
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (readEnabled && writeEnabled) begin
                  protocolError <= 1'b1;
               end else if (readEnabled || writeEnabled) begin
                  latched_op    <= writeEnabled ? OP_WRITE : OP_READ;
                  latched_index <= address[MEMORY_INDEX_WIDTH-1:0];
                  latched_data  <= writeData;
                  counter       <= writeEnabled ? WRITE_COUNT : READ_COUNT;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (counter != '0) begin
                  counter <= counter - 1'b1;
               end else begin
                  if (latched_op == OP_READ) begin
                     readData <= array_read_data;
                  end
                  functionComplete <= 1'b1;
                  state            <= DONE;
               end
            end
            DONE: begin
               if (!readEnabled && !writeEnabled) begin
                  functionComplete <= 1'b0;
                  state            <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_memory_responder.sv
// tb_ram_memory_responder
// Directed bench for ram_memory_responder with 16-word arrays, read latency 3
// and write latency 2. Instance dut_init zeroes its array after reset,
// instance dut_noinit keeps its contents across reset.
module tb_ram_memory_responder;

   logic        clock;
   logic        a_reset, b_reset;
   logic [15:0] a_address, b_address;
   logic [15:0] a_write_data, b_write_data;
   logic        a_read_en, b_read_en;
   logic        a_write_en, b_write_en;
   logic [15:0] a_read_data, b_read_data;
   logic        a_fc, b_fc;
   logic        a_ready, b_ready;
   logic        a_pe, b_pe;

   int checks;
   int failures;

   ram_memory_responder #(
      .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MEMORY_INDEX_WIDTH(4),
      .READ_LATENCY(3), .WRITE_LATENCY(2), .INIT_ON_RESET(1'b1)
   ) dut_init (
      .clock(clock), .reset(a_reset), .address(a_address), .writeData(a_write_data),
      .readEnabled(a_read_en), .writeEnabled(a_write_en), .readData(a_read_data),
      .functionComplete(a_fc), .ready(a_ready), .protocolError(a_pe)
   );

   ram_memory_responder #(
      .ADDRESS_WIDTH(16), .DATA_WIDTH(16), .MEMORY_INDEX_WIDTH(4),
      .READ_LATENCY(3), .WRITE_LATENCY(2), .INIT_ON_RESET(1'b0)
   ) dut_noinit (
      .clock(clock), .reset(b_reset), .address(b_address), .writeData(b_write_data),
      .readEnabled(b_read_en), .writeEnabled(b_write_en), .readData(b_read_data),
      .functionComplete(b_fc), .ready(b_ready), .protocolError(b_pe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic get_fc(input bit sel);
      return sel ? b_fc : a_fc;
   endfunction

   function automatic logic [15:0] get_rd(input bit sel);
      return sel ? b_read_data : a_read_data;
   endfunction

   task automatic set_req(input bit sel, input logic rd, input logic wr,
                          input logic [15:0] addr, input logic [15:0] data);
      if (sel) begin
         b_read_en = rd; b_write_en = wr; b_address = addr; b_write_data = data;
      end else begin
         a_read_en = rd; a_write_en = wr; a_address = addr; a_write_data = data;
      end
   endtask

   // Full handshake: returns edges from sampling to functionComplete (-1 on
   // timeout), the read data seen with it, and functionComplete one edge
   // after the request is released.
   task automatic access(input bit sel, input bit is_write, input logic [15:0] addr,
                         input logic [15:0] data, output int lat,
                         output logic [15:0] rdata, output logic fc_after);
      lat   = -1;
      rdata = 'x;
      @(negedge clock);
      set_req(sel, !is_write, is_write, addr, data);
      @(posedge clock);
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clock); #1;
         if (get_fc(sel)) begin
            lat   = n;
            rdata = get_rd(sel);
         end
      end
      @(negedge clock);
      set_req(sel, 1'b0, 1'b0, addr, data);
      @(posedge clock); #1;
      fc_after = get_fc(sel);
   endtask

   task automatic test_reset;
      int ready_at;
      @(negedge clock);
      a_reset = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clock);
      #1;
      checks++; if (a_fc !== 1'b0) begin failures++; $display("[TB] FAIL reset_fc: got %b expected 0", a_fc); end
      checks++; if (a_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", a_ready); end
      checks++; if (a_pe !== 1'b0) begin failures++; $display("[TB] FAIL reset_pe: got %b expected 0", a_pe); end
      checks++; if (a_read_data !== 16'h0000) begin failures++; $display("[TB] FAIL reset_rdata: got %h expected 0000", a_read_data); end
      @(negedge clock);
      a_reset  = 1'b1;
      ready_at = -1;
      for (int n = 1; n <= 40 && ready_at < 0; n++) begin
         @(posedge clock); #1;
         if (a_ready === 1'b1) ready_at = n;
      end
      checks++; if (ready_at !== 16) begin failures++; $display("[TB] FAIL init_ready_edges: got %0d expected 16", ready_at); end
   endtask

   task automatic test_read_latency;
      int lat; logic [15:0] rd; logic fa;
      access(1'b0, 1'b0, 16'h0005, 16'h0000, lat, rd, fa);
      checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL read_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 16'h0000) begin failures++; $display("[TB] FAIL read_cleared: got %h expected 0000", rd); end
      checks++; if (fa !== 1'b0) begin failures++; $display("[TB] FAIL read_release: got %b expected 0", fa); end
   endtask

   task automatic test_write_hold;
      int lat; logic [15:0] rd; logic fa;
      lat = -1;
      @(negedge clock);
      set_req(1'b0, 1'b0, 1'b1, 16'h0003, 16'hABCD);
      @(posedge clock);
      for (int n = 1; n <= 20 && lat < 0; n++) begin
         @(posedge clock); #1;
         if (a_fc) lat = n;
      end
      checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL write_latency: got %0d expected 2", lat); end
      for (int n = 0; n < 5; n++) begin
         @(posedge clock); #1;
         checks++; if (a_fc !== 1'b1) begin failures++; $display("[TB] FAIL write_hold: got %b expected 1", a_fc); end
      end
      @(negedge clock);
      set_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'hABCD);
      @(posedge clock); #1;
      checks++; if (a_fc !== 1'b0) begin failures++; $display("[TB] FAIL write_release: got %b expected 0", a_fc); end
      access(1'b0, 1'b0, 16'h0003, 16'h0000, lat, rd, fa);
      checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL readback_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 16'hABCD) begin failures++; $display("[TB] FAIL readback_data: got %h expected abcd", rd); end
   endtask

   task automatic test_aliasing;
      int lat; logic [15:0] rd; logic fa;
      access(1'b0, 1'b1, 16'h0013, 16'h1111, lat, rd, fa);
      checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL alias_write_latency: got %0d expected 2", lat); end
      checks++; if (a_read_data !== 16'hABCD) begin failures++; $display("[TB] FAIL rdata_held_after_write: got %h expected abcd", a_read_data); end
      access(1'b0, 1'b0, 16'h0003, 16'h0000, lat, rd, fa);
      checks++; if (rd !== 16'h1111) begin failures++; $display("[TB] FAIL alias_read: got %h expected 1111", rd); end
   endtask

   task automatic test_protocol_error;
      int lat; logic [15:0] rd; logic fa;
      @(negedge clock);
      set_req(1'b0, 1'b1, 1'b1, 16'h0003, 16'hDEAD);
      for (int n = 0; n < 4; n++) begin
         @(posedge clock); #1;
         checks++; if (a_fc !== 1'b0) begin failures++; $display("[TB] FAIL both_enables_fc: got %b expected 0", a_fc); end
      end
      checks++; if (a_pe !== 1'b1) begin failures++; $display("[TB] FAIL protocol_error_set: got %b expected 1", a_pe); end
      @(negedge clock);
      set_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
      repeat (2) @(posedge clock);
      access(1'b0, 1'b0, 16'h0003, 16'h0000, lat, rd, fa);
      checks++; if (rd !== 16'h1111) begin failures++; $display("[TB] FAIL no_write_on_error: got %h expected 1111", rd); end
      checks++; if (a_pe !== 1'b1) begin failures++; $display("[TB] FAIL protocol_error_sticky: got %b expected 1", a_pe); end
   endtask

   task automatic test_dropped_request;
      int first_high; int high_count;
      first_high = -1;
      high_count = 0;
      @(negedge clock);
      set_req(1'b0, 1'b1, 1'b0, 16'h0003, 16'h0000);
      @(posedge clock);
      @(negedge clock);
      set_req(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000);
      for (int n = 1; n <= 8; n++) begin
         @(posedge clock); #1;
         if (a_fc === 1'b1) begin
            high_count++;
            if (first_high < 0) first_high = n;
         end
      end
      checks++; if (first_high !== 3) begin failures++; $display("[TB] FAIL dropped_fc_edge: got %0d expected 3", first_high); end
      checks++; if (high_count !== 1) begin failures++; $display("[TB] FAIL dropped_fc_pulse: got %0d expected 1", high_count); end
      checks++; if (a_read_data !== 16'h1111) begin failures++; $display("[TB] FAIL dropped_rdata: got %h expected 1111", a_read_data); end
   endtask

   task automatic test_init_request;
      int ready_at; int fc_at; logic [15:0] rd_at_fc; int lat; logic [15:0] rd; logic fa;
      ready_at = -1;
      fc_at    = -1;
      rd_at_fc = 'x;
      @(negedge clock);
      a_reset = 1'b0;
      set_req(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
      repeat (2) @(posedge clock);
      #1;
      checks++; if (a_pe !== 1'b0) begin failures++; $display("[TB] FAIL pe_cleared_by_reset: got %b expected 0", a_pe); end
      @(negedge clock);
      a_reset = 1'b1;
      for (int n = 1; n <= 40 && fc_at < 0; n++) begin
         @(posedge clock); #1;
         if (a_ready === 1'b1 && ready_at < 0) ready_at = n;
         if (a_fc === 1'b1) begin
            fc_at    = n;
            rd_at_fc = a_read_data;
         end
      end
      checks++; if (ready_at !== 16) begin failures++; $display("[TB] FAIL init_req_ready: got %0d expected 16", ready_at); end
      checks++; if (fc_at !== 20) begin failures++; $display("[TB] FAIL init_req_fc_edge: got %0d expected 20", fc_at); end
      checks++; if (rd_at_fc !== 16'h0000) begin failures++; $display("[TB] FAIL init_req_data: got %h expected 0000", rd_at_fc); end
      @(negedge clock);
      set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      @(posedge clock);
      access(1'b0, 1'b0, 16'h0003, 16'h0000, lat, rd, fa);
      checks++; if (rd !== 16'h0000) begin failures++; $display("[TB] FAIL array_zeroed: got %h expected 0000", rd); end
   endtask

   task automatic test_no_init;
      int lat; logic [15:0] rd; logic fa;
      @(negedge clock);
      b_reset = 1'b0;
      set_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      repeat (2) @(posedge clock);
      #1;
      checks++; if (b_ready !== 1'b1) begin failures++; $display("[TB] FAIL noinit_ready: got %b expected 1", b_ready); end
      @(negedge clock);
      b_reset = 1'b1;
      access(1'b1, 1'b1, 16'h0007, 16'h1234, lat, rd, fa);
      checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL noinit_write_latency: got %0d expected 2", lat); end
      @(negedge clock);
      set_req(1'b1, 1'b0, 1'b1, 16'h0007, 16'h5555);
      @(posedge clock);
      @(negedge clock);
      b_reset = 1'b0;
      set_req(1'b1, 1'b0, 1'b0, 16'h0007, 16'h0000);
      repeat (2) begin
         @(posedge clock); #1;
         checks++; if (b_fc !== 1'b0) begin failures++; $display("[TB] FAIL abort_fc: got %b expected 0", b_fc); end
      end
      @(negedge clock);
      b_reset = 1'b1;
      access(1'b1, 1'b0, 16'h0007, 16'h0000, lat, rd, fa);
      checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL noinit_read_latency: got %0d expected 3", lat); end
      checks++; if (rd !== 16'h1234) begin failures++; $display("[TB] FAIL aborted_write_skipped: got %h expected 1234", rd); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      a_reset  = 1'b0;
      b_reset  = 1'b0;
      set_req(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      set_req(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
      test_reset();
      test_read_latency();
      test_write_hold();
      test_aliasing();
      test_protocol_error();
      test_dropped_request();
      test_init_request();
      test_no_init();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
